// File: rtl/led_mon_pkg.sv
// rtl/led_mon_pkg.sv - shared defaults and helpers for the LED range monitor
package led_mon_pkg;

    localparam int WIDTH_D     = 8;
    localparam int NCH_D       = 4;
    localparam int HOLD_D      = 16;
    localparam int CNT_W_D     = 16;
    localparam int STRETCH_W_D = $clog2(HOLD_D + 1);

    // Width of a counter that must hold the value HOLD; never narrower than 1 bit.
    function automatic int stretch_w(input int hold);
        return (hold < 1) ? 1 : $clog2(hold + 1);
    endfunction

    // Inclusive unsigned membership; an inverted range (lo > hi) is empty.
    function automatic logic in_range(input logic [31:0] lo, input logic [31:0] hi,
                                      input logic [31:0] d);
        return (lo <= d) && (d <= hi);
    endfunction

endpackage

// File: rtl/led_mon_chan.sv
// rtl/led_mon_chan.sv - one channel: compare, unknown detect, hit counter, LED stretch
module led_mon_chan
    import led_mon_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int HOLD  = HOLD_D,
    parameter int CNT_W = CNT_W_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             invert,
    input  logic             clr,
    output logic             match,
    output logic             unknown,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             led
);

    localparam int SW = stretch_w(HOLD);
    localparam logic [SW-1:0] HOLD_V = SW'(HOLD);

    logic             match_q, match_d;
    logic             unknown_q, unknown_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    st_q, st_d;
    logic             unk, hit;

    always_comb begin
        // Unknown samples never hit; synthesis treats every sample as known.
        unk       = valid && $isunknown(d);
        hit       = valid && !unk && (in_range(32'(lo), 32'(hi), 32'(d)) ^ invert);
        match_d   = hit;
        unknown_d = unk ? 1'b1 : (clr ? 1'b0 : unknown_q);
        cnt_d     = clr ? '0 : cnt_q;
        if (hit && (cnt_d != {CNT_W{1'b1}})) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
        if (hit) begin
            st_d = HOLD_V;
        end else if (st_q != '0) begin
            st_d = st_q - SW'(1);
        end else begin
            st_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q   <= 1'b0;
            unknown_q <= 1'b0;
            cnt_q     <= '0;
            st_q      <= '0;
        end else begin
            match_q   <= match_d;
            unknown_q <= unknown_d;
            cnt_q     <= cnt_d;
            st_q      <= st_d;
        end
    end

    assign match   = match_q;
    assign unknown = unknown_q;
    assign hit_cnt = cnt_q;
    assign led     = (HOLD == 0) ? match_q : (st_q != '0);

endmodule

// File: rtl/led_range_monitor.sv
// rtl/led_range_monitor.sv - multi-channel range monitor driving stretched LEDs
module led_range_monitor
    import led_mon_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int NCH   = NCH_D,
    parameter int HOLD  = HOLD_D,
    parameter int CNT_W = CNT_W_D
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0]     cfg_lo,
    input  logic [WIDTH-1:0]     cfg_hi,
    input  logic                 cfg_invert,
    input  logic                 clr,
    output logic [NCH-1:0]       match,
    output logic [NCH-1:0]       unknown,
    output logic [NCH*CNT_W-1:0] hit_cnt,
    output logic [NCH-1:0]       LEDG
);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        led_mon_chan #(
            .WIDTH (WIDTH),
            .HOLD  (HOLD),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk     (CLK),
            .rst     (RST_X),
            .valid   (in_valid[c]),
            .d       (in_data[c*WIDTH +: WIDTH]),
            .lo      (cfg_lo),
            .hi      (cfg_hi),
            .invert  (cfg_invert),
            .clr     (clr),
            .match   (match[c]),
            .unknown (unknown[c]),
            .hit_cnt (hit_cnt[c*CNT_W +: CNT_W]),
            .led     (LEDG[c])
        );
    end

endmodule

// File: tb/tb_led_range_monitor.sv
// tb/tb_led_range_monitor.sv - directed self-checking bench for led_range_monitor
module tb_led_range_monitor;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int HOLD  = 16;
    localparam int CNT_W = 4;

    logic                 CLK = 1'b0;
    logic                 RST_X = 1'b1;
    logic [NCH-1:0]       in_valid = '0;
    logic [NCH*WIDTH-1:0] in_data = '0;
    logic [WIDTH-1:0]     cfg_lo = '0;
    logic [WIDTH-1:0]     cfg_hi = '0;
    logic                 cfg_invert = 1'b0;
    logic                 clr = 1'b0;
    logic [NCH-1:0]       match;
    logic [NCH-1:0]       unknown;
    logic [NCH*CNT_W-1:0] hit_cnt;
    logic [NCH-1:0]       LEDG;

    int total = 0;
    int bad   = 0;

    led_range_monitor #(.WIDTH(WIDTH), .NCH(NCH), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_X(RST_X), .in_valid(in_valid), .in_data(in_data),
        .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_invert(cfg_invert), .clr(clr),
        .match(match), .unknown(unknown), .hit_cnt(hit_cnt), .LEDG(LEDG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       inv;
        logic [7:0] d;
        logic       exp_match;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic model_hit(input logic [7:0] lo, input logic [7:0] hi,
                                       input logic inv, input logic [7:0] d);
        if ($isunknown(d)) return 1'b0;
        return ((lo <= d) && (d <= hi)) ^ inv;
    endfunction

    initial begin
        int exp_cnt;
        int led_cnt;
        bit went_low;
        bit gap;
        logic [7:0] d1;
        logic exp_unk;

        vt[0]  = '{8'd2, 8'd5,   1'b0, 8'd1,   1'b0};
        vt[1]  = '{8'd2, 8'd5,   1'b0, 8'd2,   1'b1};
        vt[2]  = '{8'd2, 8'd5,   1'b0, 8'd5,   1'b1};
        vt[3]  = '{8'd2, 8'd5,   1'b0, 8'd6,   1'b0};
        vt[4]  = '{8'd2, 8'd5,   1'b1, 8'd7,   1'b1};
        vt[5]  = '{8'd2, 8'd5,   1'b1, 8'd3,   1'b0};
        vt[6]  = '{8'd9, 8'd3,   1'b0, 8'd5,   1'b0};
        vt[7]  = '{8'd9, 8'd3,   1'b0, 8'd9,   1'b0};
        vt[8]  = '{8'd9, 8'd3,   1'b1, 8'd5,   1'b1};
        vt[9]  = '{8'd9, 8'd3,   1'b1, 8'd0,   1'b1};
        vt[10] = '{8'd0, 8'd255, 1'b0, 8'd255, 1'b1};
        vt[11] = '{8'd0, 8'd0,   1'b0, 8'd0,   1'b1};

        #1;
        chk("reset_match", 32'(match), 32'd0);
        chk("reset_unknown", 32'(unknown), 32'd0);
        chk("reset_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("reset_ledg", 32'(LEDG), 32'd0);
        #12 RST_X = 1'b0;
        tick();

        // Membership / invert / empty-range table on channel 0.
        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cfg_lo = vt[i].lo;
            cfg_hi = vt[i].hi;
            cfg_invert = vt[i].inv;
            in_data[7:0] = vt[i].d;
            in_valid = 4'b0001;
            tick();
            if (vt[i].exp_match) exp_cnt++;
            chk($sformatf("vec%0d_match0", i), 32'(match[0]), 32'(vt[i].exp_match));
            chk($sformatf("vec%0d_others", i), 32'(match[3:1]), 32'd0);
            chk($sformatf("vec%0d_cnt0", i), 32'(hit_cnt[3:0]), 32'(exp_cnt));
        end
        in_valid = '0;
        tick();
        chk("match_pulse_drops", 32'(match), 32'd0);

        // Unknown sample on channel 1 with invert set.
        cfg_lo = 8'd2; cfg_hi = 8'd5; cfg_invert = 1'b1;
        in_data[15:8] = 8'hxx;
        d1 = in_data[15:8];
        exp_unk = $isunknown(d1);
        in_valid = 4'b0010;
        tick();
        chk("unk_match1", 32'(match[1]), 32'(model_hit(8'd2, 8'd5, 1'b1, d1)));
        chk("unk_flag_set", 32'(unknown[1]), 32'(exp_unk));
        in_valid = '0;
        in_data[15:8] = 8'd0;
        tick(); tick();
        chk("unk_flag_held", 32'(unknown[1]), 32'(exp_unk));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("unk_clr_alone", 32'(unknown[1]), 32'd0);
        chk("cnt_clr_alone", 32'(hit_cnt), 32'd0);
        clr = 1'b1;
        in_data[15:8] = 8'hxx;
        d1 = in_data[15:8];
        in_valid = 4'b0010;
        tick();
        clr = 1'b0;
        in_valid = '0;
        in_data[15:8] = 8'd0;
        chk("unk_clr_with_x", 32'(unknown[1]), 32'($isunknown(d1)));

        // Let all stretches expire, then a single hit on channel 2.
        cfg_lo = 8'd2; cfg_hi = 8'd5; cfg_invert = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("leds_idle", 32'(LEDG), 32'd0);
        in_data[23:16] = 8'd3;
        in_valid = 4'b0100;
        tick();
        in_valid = '0;
        chk("stretch_start_match", 32'(match[2]), 32'd1);
        chk("stretch_start_led", 32'(LEDG[2]), 32'd1);
        led_cnt = int'(LEDG[2]);
        for (int i = 0; i < 29; i++) begin
            tick();
            led_cnt += int'(LEDG[2]);
        end
        chk("stretch_single_len", 32'(led_cnt), 32'd16);

        // Retrigger 10 cycles after the first hit.
        in_valid = 4'b0100;
        tick();
        in_valid = '0;
        led_cnt = int'(LEDG[2]);
        went_low = 1'b0;
        gap = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) in_valid = 4'b0100;
            tick();
            in_valid = '0;
            if (!LEDG[2]) went_low = 1'b1;
            else if (went_low) gap = 1'b1;
            led_cnt += int'(LEDG[2]);
        end
        chk("stretch_retrig_len", 32'(led_cnt), 32'd26);
        chk("stretch_retrig_gap", 32'(gap), 32'd0);

        // Asynchronous reset in the middle of a stretch on channel 3.
        in_data[31:24] = 8'd4;
        in_valid = 4'b1000;
        tick();
        in_valid = '0;
        tick(); tick();
        chk("pre_reset_led3", 32'(LEDG[3]), 32'd1);
        #2 RST_X = 1'b1;
        #1;
        chk("async_reset_ledg", 32'(LEDG), 32'd0);
        chk("async_reset_cnt", 32'(hit_cnt), 32'd0);
        chk("async_reset_match", 32'(match), 32'd0);
        chk("async_reset_unknown", 32'(unknown), 32'd0);
        #2 RST_X = 1'b0;
        tick();
        chk("after_reset_ledg", 32'(LEDG), 32'd0);

        // Saturation, clear-with-hit, and all channels together.
        cfg_lo = 8'd0; cfg_hi = 8'd255; cfg_invert = 1'b0;
        in_data = '0;
        in_valid = 4'b0001;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt0", 32'(hit_cnt[3:0]), 32'd15);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_hit_cnt0", 32'(hit_cnt[3:0]), 32'd1);
        in_valid = 4'b1111;
        tick();
        in_valid = '0;
        chk("all_ch_match", 32'(match), 32'hf);
        chk("all_ch_cnt", 32'(hit_cnt), 32'h1112);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
